// File: rtl/rgbled_decoder.sv
// SPI-mode-0 frame receiver feeding a WS2812-style single-wire LED serializer.
// state    | meaning
// IDLE     | line low, waiting for a pending frame
// BIT_HIGH | high phase of current bit (T1H or T0H cycles)
// BIT_LOW  | low phase completing the TBIT bit period
// LATCH    | TRESET low cycles so the LED chain latches colours
module rgbled_decoder #(
  parameter int NUM_LEDS     = 3,
  parameter int BITS_PER_LED = 24,
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int TBIT         = 12,
  parameter int TRESET       = 600
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic led_dout,
  output logic busy
);
  localparam int N    = NUM_LEDS * BITS_PER_LED;
  localparam int CW   = $clog2(N + 1);
  localparam int TMAX = (TRESET > TBIT) ? TRESET : TBIT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BIT_HIGH = 2'd1;
  localparam logic [1:0] BIT_LOW  = 2'd2;
  localparam logic [1:0] LATCH    = 2'd3;

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

  // chip select idles high through reset so release never fakes a cs edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  logic [N-1:0]  shreg;
  logic [N-1:0]  frame_buf;
  logic [CW-1:0] bit_cnt;
  logic          miso_q;
  logic          frame_done;

  assign frame_done = cs_rise && (bit_cnt == CW'(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      frame_buf <= '0;
      bit_cnt   <= '0;
      miso_q    <= 1'b0;
    end else begin
      if (cs_fall)
        bit_cnt <= '0;
      else if (sclk_rise && !cs_s && (bit_cnt != CW'(N)))
        bit_cnt <= bit_cnt + 1'b1;

      if (sclk_rise && !cs_s)
        shreg <= {shreg[N-2:0], mosi_s};

      // cs falling edge presents the first bit before the master's first rising edge
      if (cs_s)
        miso_q <= 1'b0;
      else if (cs_fall || sclk_fall)
        miso_q <= shreg[N-1];

      if (frame_done)
        frame_buf <= shreg;
    end
  end

  assign spi_miso = miso_q;

  logic [1:0]    state, state_nxt;
  logic [N-1:0]  oreg;
  logic [CW-1:0] obit;
  logic [TW-1:0] timer;
  logic          pending;
  logic          led_q, busy_q;
  logic          last_bit;
  logic          start;

  function automatic logic [TW-1:0] high_len(input logic b);
    return b ? TW'(T1H - 1) : TW'(T0H - 1);
  endfunction

  function automatic logic [TW-1:0] low_len(input logic b);
    return b ? TW'(TBIT - T1H - 1) : TW'(TBIT - T0H - 1);
  endfunction

  assign last_bit = (obit == CW'(N - 1));
  assign start    = (state == IDLE) && pending;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pending) state_nxt = BIT_HIGH;
      BIT_HIGH: if (timer == '0) state_nxt = BIT_LOW;
      BIT_LOW:  if (timer == '0) state_nxt = last_bit ? LATCH : BIT_HIGH;
      LATCH:    if (timer == '0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      oreg    <= '0;
      obit    <= '0;
      timer   <= '0;
      pending <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      led_q  <= (state_nxt == BIT_HIGH);
      busy_q <= (state_nxt != IDLE);

      // a frame landing on the start cycle keeps pending set, so it follows
      if (frame_done)
        pending <= 1'b1;
      else if (start)
        pending <= 1'b0;

      case (state)
        IDLE: begin
          if (pending) begin
            oreg  <= frame_buf;
            obit  <= '0;
            timer <= high_len(frame_buf[N-1]);
          end
        end
        BIT_HIGH: begin
          if (timer == '0)
            timer <= low_len(oreg[N-1]);
          else
            timer <= timer - 1'b1;
        end
        BIT_LOW: begin
          if (timer == '0) begin
            if (last_bit) begin
              timer <= TW'(TRESET - 1);
            end else begin
              oreg  <= {oreg[N-2:0], 1'b0};
              obit  <= obit + 1'b1;
              timer <= high_len(oreg[N-2]);
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LATCH: begin
          if (timer != '0)
            timer <= timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign led_dout = led_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rgbled_decoder.sv
// Bench for rgbled_decoder: SPI frames in, decoded LED pulse train checked against a frame scoreboard.
module tb_rgbled_decoder;
  localparam int N         = 72;
  localparam int T0H       = 4;
  localparam int T1H       = 8;
  localparam int TBIT      = 12;
  localparam int TRESET    = 600;
  localparam int SCLK_HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, led_dout, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] sb[$];

  always #50 clk = ~clk;

  rgbled_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .led_dout (led_dout),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // MSB-first mode-0 transfer; miso captured just before each rising edge
  task automatic spi_send(input logic [127:0] data, input int nbits, output logic [127:0] cap);
    cap = '0;
    spi_cs_n = 1'b0;
    repeat (SCLK_HALF) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = data[i];
      repeat (SCLK_HALF) @(negedge clk);
      cap = {cap[126:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (SCLK_HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (SCLK_HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    if (nbits >= N) sb.push_back(data[N-1:0]);
    repeat (SCLK_HALF) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (((sb.size() != 0) || busy) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", (k < budget), 1);
  endtask

  // pulse-train monitor: decodes bits by high width and checks bit/latch timing
  int hi, lo, last_hi, mon_n, busy_len, busy_cycles, high_cycles;
  logic prev_d, prev_busy, bitv;
  logic [N-1:0] rx;

  initial begin
    hi = 0; lo = 0; last_hi = 0; mon_n = 0; busy_len = 0;
    busy_cycles = 0; high_cycles = 0;
    prev_d = 1'b0; prev_busy = 1'b0; rx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi = 0; lo = 0; mon_n = 0; busy_len = 0;
        prev_d = 1'b0; prev_busy = 1'b0; rx = '0;
      end else begin
        if (busy) begin
          busy_cycles++;
          busy_len++;
        end
        if (led_dout) high_cycles++;
        if (prev_busy && !busy) begin
          check("frame_bits", mon_n, N);
          check("latch_len", lo, TBIT - last_hi + TRESET);
          check("busy_len", busy_len, N * TBIT + TRESET);
          check("sb_nonempty", (sb.size() != 0), 1);
          if (sb.size() != 0) check("frame_data", rx, sb.pop_front());
          mon_n = 0;
          busy_len = 0;
        end
        if (led_dout) begin
          if (!prev_d) begin
            if (mon_n > 0) check("bit_low", lo, TBIT - last_hi);
            hi = 0;
          end
          hi++;
        end else begin
          if (prev_d) begin
            last_hi = hi;
            bitv = (hi > (T0H + T1H) / 2);
            check("bit_high", hi, bitv ? T1H : T0H);
            rx = {rx[N-2:0], bitv};
            mon_n++;
            lo = 0;
          end
          lo++;
        end
        prev_d = led_dout;
        prev_busy = busy;
      end
    end
  end

  initial begin
    logic [127:0] cap;
    int h0, b0, k;
    repeat (3) @(negedge clk);
    check("rst_led", led_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", spi_miso, 0);
    rst = 1'b0;

    h0 = high_cycles;
    b0 = busy_cycles;
    repeat (200) @(negedge clk);
    check("idle_quiet", high_cycles - h0, 0);

    spi_send(128'hA5, 8, cap);
    check("miso_after_rst", cap[7:0], 8'h00);
    check("byte_no_busy", busy_cycles - b0, 0);

    spi_send(128'hFF0000_00FF00_0000FF, 72, cap);
    wait_done(6000);

    b0 = busy_cycles;
    h0 = high_cycles;
    spi_send(128'h2A_5A5A_5A5A_5A5A_5A5A, 71, cap);
    repeat (300) @(negedge clk);
    check("short_no_busy", busy_cycles - b0, 0);
    check("short_no_led", high_cycles - h0, 0);

    spi_send(128'hDEAD_1234_5678_9ABC_DEF0, 80, cap);
    wait_done(6000);

    spi_send(128'h0F1E2D_3C4B5A_697887, 72, cap);
    spi_send(128'h3CC355_AA00FF_817E99, 72, cap);
    wait_done(8000);

    spi_send(128'hA5, 8, cap);
    check("miso_prev", cap[7:0], 8'h3C);

    spi_send(128'h123456_ABCDEF_0F0F0F, 72, cap);
    k = 0;
    while (!busy && (k < 200)) begin @(negedge clk); k++; end
    check("start_timeout", (k < 200), 1);
    repeat (300) @(negedge clk);
    k = 0;
    while (!led_dout && (k < 50)) begin @(negedge clk); k++; end
    #10 rst = 1'b1;
    #1;
    check("rst_mid_led", led_dout, 0);
    check("rst_mid_busy", busy, 0);
    sb.delete();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    h0 = high_cycles;
    b0 = busy_cycles;
    repeat (2500) @(negedge clk);
    check("post_rst_led", high_cycles - h0, 0);
    check("post_rst_busy", busy_cycles - b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgbled_decoder.md
RGBLED_DECODER -- requirements
Module: rgbled_decoder

Interface
REQ-001 Parameter NUM_LEDS, default 3, number of chained RGB LEDs driven.
REQ-002 Parameter BITS_PER_LED, default 24, colour bits per LED (8 G, 8 R, 8 B, sent verbatim).
REQ-003 Parameters T0H=4, T1H=8, TBIT=12, TRESET=600, in clk cycles (10 MHz clk: 0.4 us / 0.8 us / 1.2 us / 60 us).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 spi_sclk  input  1  SPI clock, asynchronous to clk.
REQ-008 spi_cs_n  input  1  SPI chip select, active low.
REQ-009 spi_mosi  input  1  SPI serial data in.
REQ-010 spi_miso  output  1  SPI serial data out (shift-register MSB).
REQ-011 led_dout  output  1  single-wire WS2812-style LED data.
REQ-012 busy  output  1  high while a frame or latch gap is being transmitted.

Function
REQ-013 spi_sclk, spi_cs_n, spi_mosi SHALL pass through 2-flop synchronizers; SCLK edges detected in clk domain; clk SHALL be at least 4x SCLK.
REQ-014 SPI mode 0, MSB first: MOSI sampled on each synchronized SCLK rising edge while cs_n low, shifted into an N = NUM_LEDS*BITS_PER_LED (72) bit shift register.
REQ-015 Bit counter cleared on cs_n falling edge, increments per sampled bit, saturates at N.
REQ-016 On cs_n rising edge: if count = N, shift register (last N bits received) SHALL copy to frame buffer and set pending; if count < N, frame discarded, buffer unchanged.
REQ-017 spi_miso SHALL present shift-register MSB, updated after each SCLK falling edge; 0 while cs_n high.
REQ-018 First 24 bits received belong to LED0 and SHALL be transmitted first, MSB first.
REQ-019 Serializer FSM states: IDLE, BIT_HIGH, BIT_LOW, LATCH.
REQ-020 IDLE: led_dout=0, busy=0; if pending, copy frame buffer to output shift register, clear pending, enter BIT_HIGH next cycle.
REQ-021 BIT_HIGH: led_dout=1 for T1H cycles if current bit is 1, T0H if 0; then BIT_LOW.
REQ-022 BIT_LOW: led_dout=0 for TBIT minus high time; then next bit to BIT_HIGH, or after bit N to LATCH.
REQ-023 LATCH: led_dout=0 for TRESET cycles, then IDLE.
REQ-024 busy=1 in BIT_HIGH, BIT_LOW, LATCH.
REQ-025 Frame completing while busy SHALL overwrite the frame buffer and set pending; the running transmission is not altered; newest pending frame sent after LATCH.
REQ-026 Total transmission: N*TBIT + TRESET cycles (864 + 600 at defaults).
REQ-027 Pending set and IDLE-start on the same cycle: pending set wins, so the new frame is sent.

Reset
REQ-028 While rst high: led_dout=0, spi_miso=0, busy=0, FSM IDLE, shift registers, counters, frame buffer cleared, pending cleared.
REQ-029 Reset mid-frame (SPI or LED) SHALL abort immediately; no partial frame latched or resumed after release.
REQ-030 After reset release with no SPI activity, led_dout stays 0 indefinitely.

Verification
REQ-031 Send 72 bits 0xFF0000_00FF00_0000FF, raise cs_n -> led_dout shows 8 pulses of 8 high/4 low, 16 of 4/8, ..., matching bit order; then 600 low cycles; busy falls.
REQ-032 Send only 71 bits then raise cs_n -> no led_dout activity, busy stays 0.
REQ-033 Send 80 bits -> last 72 bits transmitted.
REQ-034 During transmission of frame A, send frame B -> A completes unchanged, B transmitted immediately after A's latch gap.
REQ-035 Assert rst midway through a transmission -> led_dout=0 and busy=0 at once; nothing transmitted after release.
REQ-036 Send 0xA5 first byte while monitoring spi_miso -> spi_miso reproduces previously shifted data MSB first (all zeros after reset).
